if_fetch_stage: RTL and testbench

- Instruction-fetch stage: PC register, instruction-ROM addressing, and the IF/ID pipeline register that feeds the decode path.
- The decode path (register-select and immediate-extend logic) consumes if_order, if_pc and if_pc_plus_4 from this block.
- Owns stall on hazard conflict, flush on taken redirect, and the syscall pause/resume state machine with Go-button resume.

---
 rtl/mips_pkg.sv | 14 +
 rtl/go_edge_detect.sv | 21 ++
 rtl/if_fetch_stage.sv | 124 ++++++++++++
 tb/tb_if_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS pipeline front end.
package mips_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
  // R1 value that lets a syscall exit instead of pausing the pipeline.
  localparam logic [31:0] SYSCALL_EXIT_CODE = 32'h0000_0022;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

endpackage

// File: rtl/go_edge_detect.sv
// Rising-edge detector for a level front-panel button; a held button yields one pulse.
module go_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_rise
);

  logic r_btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign btn_rise = btn & ~r_btn_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, ROM addressing, IF/ID register, syscall pause/resume.
// Optional perf counters (cycle_cnt, stall_cnt) enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter int          ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              conflict,
  input  logic              syscall_stop,
  input  logic              go,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       pc,
  output logic [31:0]       if_order,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus_4,
  output logic              if_valid,
  output logic              halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         w_go_rise;
  logic         w_do_redirect;
  logic         w_do_advance;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_plus_4;
  logic [31:0]  w_redirect_aligned;

  go_edge_detect u_go_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (go),
    .btn_rise (w_go_rise)
  );

  assign w_pc_plus_4        = r_pc + 32'd4;
  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // A go edge arriving with the syscall satisfies it, so the cycle advances normally.
  always_comb begin
    w_state_next  = r_state;
    w_do_redirect = 1'b0;
    w_do_advance  = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect) begin
          w_do_redirect = 1'b1;
        end else if (syscall_stop && !w_go_rise) begin
          w_state_next = HALT;
        end else if (!conflict) begin
          w_do_advance = 1'b1;
        end
      end
      HALT: begin
        if (w_go_rise) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      if_order     <= NOP_INSTR;
      if_pc        <= 32'd0;
      if_pc_plus_4 <= 32'd0;
      if_valid     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_do_redirect) begin
        r_pc     <= w_redirect_aligned;
        if_order <= NOP_INSTR;
        if_valid <= 1'b0;
      end else if (w_do_advance) begin
        r_pc         <= w_pc_plus_4;
        if_order     <= rom_data;
        if_pc        <= r_pc;
        if_pc_plus_4 <= w_pc_plus_4;
        if_valid     <= 1'b1;
      end
    end
  end

  assign pc       = r_pc;
  assign rom_addr = r_pc[ROM_AW+1:2];
  assign halted   = (r_state == HALT);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (r_state != HALT && r_cycle_cnt != 32'hFFFF_FFFF) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (r_state == RUN && conflict && !redirect && r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (define IF_PERF_CNT_EN to check counters).
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        conflict;
  logic        syscall_stop;
  logic        go;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] if_order;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        if_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .conflict     (conflict),
    .syscall_stop (syscall_stop),
    .go           (go),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pc           (pc),
    .if_order     (if_order),
    .if_pc        (if_pc),
    .if_pc_plus_4 (if_pc_plus_4),
    .if_valid     (if_valid),
    .halted       (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // Word 0 holds addi; every other word encodes its own address for easy tracking.
  assign rom_data = (rom_addr == 10'd0) ? 32'h2008_0005 : (32'hA500_0000 | {22'd0, rom_addr});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end else begin
      $display("ok   %s = %h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; conflict = 1'b0; syscall_stop = 1'b0; go = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0;
    #2;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_order", if_order, 32'h0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    #10 rst_n = 1'b1;

    // Free running fetch
    step(); check_eq("f1_if_order", if_order, 32'h2008_0005);
    step();
    step();
    check_eq("f3_pc", pc, 32'h0C);
    check_eq("f3_if_pc", if_pc, 32'h08);
    check_eq("f3_if_pc4", if_pc_plus_4, 32'h0C);
    check_eq("f3_if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("f3_if_order", if_order, 32'hA500_0002);
    step(); check_eq("f4_pc", pc, 32'h10);

    // Load-use stall for two cycles
    conflict = 1'b1;
    step(); check_eq("stall1_pc", pc, 32'h10); check_eq("stall1_order", if_order, 32'hA500_0003);
    step(); check_eq("stall2_pc", pc, 32'h10); check_eq("stall2_order", if_order, 32'hA500_0003);
    conflict = 1'b0;
    step(); check_eq("rel_pc", pc, 32'h14); check_eq("rel_order", if_order, 32'hA500_0004);

    // Redirect overrides conflict; low target bits are dropped
    redirect = 1'b1; redirect_pc = 32'h43; conflict = 1'b1;
    step();
    check_eq("redir_pc", pc, 32'h40);
    check_eq("redir_valid", {31'd0, if_valid}, 32'd0);
    check_eq("redir_order", if_order, 32'h0);
    redirect = 1'b0; conflict = 1'b0;
    step();
    check_eq("post_redir_if_pc", if_pc, 32'h40);
    check_eq("post_redir_valid", {31'd0, if_valid}, 32'd1);
    check_eq("post_redir_order", if_order, 32'hA500_0010);
`ifdef IF_PERF_CNT_EN
    check_eq("stall_cnt_2", stall_cnt, 32'd2);
`endif

    // Syscall pause at 0x20
    redirect = 1'b1; redirect_pc = 32'h20;
    step(); redirect = 1'b0;
    check_eq("at20_pc", pc, 32'h20);
    syscall_stop = 1'b1;
    step(); syscall_stop = 1'b0;
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    check_eq("halt_pc", pc, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h80;
    step(); redirect = 1'b0;
    check_eq("halt_ign_redir", pc, 32'h20);
    check_eq("halt_still", {31'd0, halted}, 32'd1);

    // Go held high: one resume only
    go = 1'b1;
    step();
    check_eq("go_run", {31'd0, halted}, 32'd0);
    check_eq("go_pc_hold", pc, 32'h20);
    step(); check_eq("go_pc_adv", pc, 32'h24);
    syscall_stop = 1'b1;
    step(); syscall_stop = 1'b0;
    check_eq("held_go_rehalt", {31'd0, halted}, 32'd1);
    step(); step();
    check_eq("held_go_no_resume", {31'd0, halted}, 32'd1);
    check_eq("held_go_pc", pc, 32'h24);
    go = 1'b0;
    step();
    go = 1'b1;
    step(); go = 1'b0;
    check_eq("go2_run", {31'd0, halted}, 32'd0);
    step(); check_eq("go2_pc", pc, 32'h28);

    // Syscall together with a fresh go edge is a normal advance
    syscall_stop = 1'b1; go = 1'b1;
    step(); syscall_stop = 1'b0; go = 1'b0;
    check_eq("sys_go_halted", {31'd0, halted}, 32'd0);
    check_eq("sys_go_pc", pc, 32'h2C);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0;
    check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_pre_rom", {22'd0, rom_addr}, 32'h3FF);
    step();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_rom", {22'd0, rom_addr}, 32'h0);
    check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_if_pc4", if_pc_plus_4, 32'h0);

    // Async reset in the middle of HALT
    syscall_stop = 1'b1;
    step(); syscall_stop = 1'b0;
    check_eq("pre_rst_halted", {31'd0, halted}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_halted", {31'd0, halted}, 32'd0);
    check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check_eq("arst_cycle_cnt", cycle_cnt, 32'd0);
    check_eq("arst_stall_cnt", stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
